// File: rtl/vregfile_pkg.sv
// vregfile_pkg: shared types and default geometry for the vector register file.
// The defaults are also used by the vector ALU and by decode. The file itself
// takes its geometry from its own parameters and uses these values only as
// their defaults.
package vregfile_pkg;

    localparam int VRF_LANES = 6;   // element lanes per vector register
    localparam int VRF_EW    = 8;   // element width in bits
    localparam int VRF_NREGS = 10;  // number of vector registers
    localparam int VRF_SREG  = 0;   // register whose lanes form the scalar bank
    localparam int VRF_IW    = 4;   // register/lane index width

    // One vector register at the default geometry.
    typedef logic [VRF_LANES-1:0][VRF_EW-1:0] vec_t;

    // Background-clear controller states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } vrf_state_e;

endpackage

// File: rtl/vrf_fwd_mux.sv
// vrf_fwd_mux: builds the value seen on one read port. It starts from the
// stored row, merges in the write that is being accepted in this cycle, and
// can then replicate a single lane to every lane for scalar broadcast.
// Ports:
//   row_i        stored row for the read index (zero when out of range)
//   wd_i         write data of the current cycle
//   mask_i       per-lane write mask (vector writes)
//   vec_hit_i    an accepted vector write targets this row
//   scal_hit_i   an accepted scalar write targets this row
//   scal_lane_i  lane written by the scalar write
//   bcast_i      replicate lane bcast_lane_i to all lanes
//   bcast_lane_i lane to broadcast (out-of-range lane reads 0)
//   rd_o         read data
module vrf_fwd_mux #(
    parameter int LANES = 6,
    parameter int EW    = 8,
    parameter int IW    = 4
) (
    input  logic [LANES-1:0][EW-1:0] row_i,
    input  logic [LANES-1:0][EW-1:0] wd_i,
    input  logic [LANES-1:0]         mask_i,
    input  logic                     vec_hit_i,
    input  logic                     scal_hit_i,
    input  logic [IW-1:0]            scal_lane_i,
    input  logic                     bcast_i,
    input  logic [IW-1:0]            bcast_lane_i,
    output logic [LANES-1:0][EW-1:0] rd_o
);

    logic [LANES-1:0][EW-1:0] merged_s;
    logic [EW-1:0]            lane_s;

    // Merge the in-flight write into the stored row, lane by lane.
    always_comb begin
        merged_s = row_i;
        for (int i = 0; i < LANES; i++) begin
            if (vec_hit_i && mask_i[i]) begin
                merged_s[i] = wd_i[i];
            end else if (scal_hit_i && (32'(scal_lane_i) == i)) begin
                merged_s[i] = wd_i[0];
            end else begin
                merged_s[i] = row_i[i];
            end
        end
    end

    // Select the broadcast lane. The select is written as a compare loop so
    // that an index past the last lane returns zero.
    always_comb begin
        lane_s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (32'(bcast_lane_i) == i) begin
                lane_s = merged_s[i];
            end else begin
                lane_s = lane_s;
            end
        end
    end

    // Final port value: either the full merged row or one lane replicated.
    always_comb begin
        if (bcast_i) begin
            rd_o = {LANES{lane_s}};
        end else begin
            rd_o = merged_s;
        end
    end

endmodule

// File: rtl/vregfile_param.sv
// vregfile_param: parametrised vector register file.
// It has two combinational read ports with write-to-read forwarding, one
// write port with a per-lane mask, and a scalar mode that treats the lanes of
// register SREG as scalar registers. A multi-cycle background clear runs
// through every register one at a time.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   WE3, A3, WD3   write enable, write index, write data
//   WMask          per-lane write mask (vector writes)
//   SFlag, Bcast   scalar mode / broadcast of a scalar lane on RD2
//   A1, A2         read indices; RD1, RD2 read data
//   clr_req        start a background clear; busy is high while it runs
//   wr_err         one-cycle pulse for each rejected write
module vregfile_param
    import vregfile_pkg::*;
#(
    parameter int LANES = VRF_LANES,
    parameter int EW    = VRF_EW,
    parameter int NREGS = VRF_NREGS,
    parameter int SREG  = VRF_SREG,
    parameter int IW    = VRF_IW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     WE3,
    input  logic [IW-1:0]            A1,
    input  logic [IW-1:0]            A2,
    input  logic [IW-1:0]            A3,
    input  logic [LANES-1:0][EW-1:0] WD3,
    input  logic [LANES-1:0]         WMask,
    input  logic                     SFlag,
    input  logic                     Bcast,
    input  logic                     clr_req,
    output logic [LANES-1:0][EW-1:0] RD1,
    output logic [LANES-1:0][EW-1:0] RD2,
    output logic                     busy,
    output logic                     wr_err
);

    typedef logic [LANES-1:0][EW-1:0] row_t;
    localparam logic [IW-1:0] SREG_IX = IW'(SREG);

    vrf_state_e    state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    row_t          rf_q [NREGS];
    row_t          rf_d [NREGS];
    logic          busy_q, busy_d;
    logic          wr_err_q, wr_err_d;

    logic          accept_s, vec_ok_s, sc_ok_s;
    logic [IW-1:0] idx2_s;
    row_t          row1_s, row2_s;

    // A write is accepted only in IDLE and only when no clear starts in the
    // same cycle. The range check depends on the mode.
    always_comb begin
        accept_s = WE3 && (state_q == IDLE) && !clr_req;
        vec_ok_s = accept_s && !SFlag && (32'(A3) < NREGS);
        sc_ok_s  = accept_s &&  SFlag && (32'(A3) < LANES);
        wr_err_d = WE3 && !(vec_ok_s || sc_ok_s);
    end

    // Clear controller next state. cnt walks every register once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (32'(cnt_q) == NREGS - 1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    // Array next state: the clear step, or one masked vector write, or one
    // scalar lane write.
    always_comb begin
        rf_d = rf_q;
        for (int r = 0; r < NREGS; r++) begin
            if ((state_q == CLEAR) && (32'(cnt_q) == r)) begin
                rf_d[r] = '0;
            end else if (vec_ok_s && (32'(A3) == r)) begin
                for (int l = 0; l < LANES; l++) begin
                    if (WMask[l]) begin
                        rf_d[r][l] = WD3[l];
                    end else begin
                        rf_d[r][l] = rf_q[r][l];
                    end
                end
            end else if (sc_ok_s && (r == SREG)) begin
                for (int l = 0; l < LANES; l++) begin
                    if (32'(A3) == l) begin
                        rf_d[r][l] = WD3[0];
                    end else begin
                        rf_d[r][l] = rf_q[r][l];
                    end
                end
            end else begin
                rf_d[r] = rf_q[r];
            end
        end
    end

    // Row lookup for both ports. An index with no matching register reads 0.
    // In scalar mode RD2 always reads from the scalar bank.
    always_comb begin
        idx2_s = SFlag ? SREG_IX : A2;
        row1_s = '0;
        row2_s = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (32'(A1) == r) begin
                row1_s = rf_q[r];
            end else begin
                row1_s = row1_s;
            end
            if (32'(idx2_s) == r) begin
                row2_s = rf_q[r];
            end else begin
                row2_s = row2_s;
            end
        end
    end

    vrf_fwd_mux #(.LANES(LANES), .EW(EW), .IW(IW)) u_fwd_rd1 (
        .row_i        (row1_s),
        .wd_i         (WD3),
        .mask_i       (WMask),
        .vec_hit_i    (vec_ok_s && (A1 == A3)),
        .scal_hit_i   (sc_ok_s && (A1 == SREG_IX)),
        .scal_lane_i  (A3),
        .bcast_i      (1'b0),
        .bcast_lane_i ({IW{1'b0}}),
        .rd_o         (RD1)
    );

    vrf_fwd_mux #(.LANES(LANES), .EW(EW), .IW(IW)) u_fwd_rd2 (
        .row_i        (row2_s),
        .wd_i         (WD3),
        .mask_i       (WMask),
        .vec_hit_i    (vec_ok_s && (idx2_s == A3)),
        .scal_hit_i   (sc_ok_s && (idx2_s == SREG_IX)),
        .scal_lane_i  (A3),
        .bcast_i      (SFlag && Bcast),
        .bcast_lane_i (A2),
        .rd_o         (RD2)
    );

    // State, array and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rf_q     <= '{default: '0};
            busy_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rf_q     <= rf_d;
            busy_q   <= busy_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign busy   = busy_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_vregfile_param.sv
// tb_vregfile_param: directed, table-driven bench for vregfile_param at the
// default geometry (6 lanes x 8 bits, 10 registers, scalar bank in r0).
module tb_vregfile_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        WE3, SFlag, Bcast, clr_req;
    logic [3:0]  A1, A2, A3;
    logic [47:0] WD3;
    logic [5:0]  WMask;
    logic [47:0] RD1, RD2;
    logic        busy, wr_err;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt;
    logic drove;

    typedef struct {
        logic        we3, sflag, bcast;
        logic [3:0]  a1, a2, a3;
        logic [47:0] wd;
        logic [5:0]  mask;
        logic [47:0] e_rd1, e_rd2;
        logic        e_err;
    } vec_s;

    vec_s vt [13];

    vregfile_param dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .WE3     (WE3),
        .A1      (A1),
        .A2      (A2),
        .A3      (A3),
        .WD3     (WD3),
        .WMask   (WMask),
        .SFlag   (SFlag),
        .Bcast   (Bcast),
        .clr_req (clr_req),
        .RD1     (RD1),
        .RD2     (RD2),
        .busy    (busy),
        .wr_err  (wr_err)
    );

    always #5 clk = ~clk;

    function automatic vec_s mk(input logic we, input logic sf, input logic bc,
                                input logic [3:0] a1, input logic [3:0] a2,
                                input logic [3:0] a3, input logic [47:0] wd,
                                input logic [5:0] m, input logic [47:0] r1,
                                input logic [47:0] r2, input logic e);
        vec_s v;
        v.we3 = we; v.sflag = sf; v.bcast = bc;
        v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.wd = wd; v.mask = m;
        v.e_rd1 = r1; v.e_rd2 = r2; v.e_err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        WE3 = 1'b0; SFlag = 1'b0; Bcast = 1'b0; clr_req = 1'b0;
        A1 = 4'd0; A2 = 4'd0; A3 = 4'd0; WD3 = 48'h0; WMask = 6'h00;
    endtask

    initial begin
        // we sf bc a1 a2 a3 wd mask exp_rd1 exp_rd2 exp_err
        vt[0]  = mk(1'b0,1'b0,1'b0,4'd0, 4'd9, 4'd0, 48'h0,            6'h00,     48'h0,            48'h0,            1'b0);
        vt[1]  = mk(1'b1,1'b0,1'b0,4'd7, 4'd7, 4'd7, 48'h060504030201, 6'b101010, 48'h060004000200, 48'h060004000200, 1'b0);
        vt[2]  = mk(1'b0,1'b0,1'b0,4'd7, 4'd3, 4'd0, 48'h0,            6'h00,     48'h060004000200, 48'h0,            1'b0);
        vt[3]  = mk(1'b1,1'b1,1'b0,4'd0, 4'd5, 4'd2, 48'h0000000000AB, 6'h00,     48'h000000AB0000, 48'h000000AB0000, 1'b0);
        vt[4]  = mk(1'b0,1'b1,1'b1,4'd7, 4'd2, 4'd0, 48'h0,            6'h00,     48'h060004000200, 48'hABABABABABAB, 1'b0);
        vt[5]  = mk(1'b0,1'b1,1'b0,4'd13,4'd2, 4'd0, 48'h0,            6'h00,     48'h0,            48'h000000AB0000, 1'b0);
        vt[6]  = mk(1'b1,1'b0,1'b0,4'd7, 4'd12,4'd12,48'hFFFFFFFFFFFF, 6'h3F,     48'h060004000200, 48'h0,            1'b1);
        vt[7]  = mk(1'b1,1'b1,1'b0,4'd0, 4'd1, 4'd6, 48'h000000000055, 6'h3F,     48'h000000AB0000, 48'h000000AB0000, 1'b1);
        vt[8]  = mk(1'b0,1'b0,1'b0,4'd7, 4'd0, 4'd0, 48'h0,            6'h00,     48'h060004000200, 48'h000000AB0000, 1'b0);
        vt[9]  = mk(1'b1,1'b0,1'b0,4'd0, 4'd0, 4'd0, 48'h112233445566, 6'b000001, 48'h000000AB0066, 48'h000000AB0066, 1'b0);
        vt[10] = mk(1'b1,1'b1,1'b1,4'd0, 4'd4, 4'd4, 48'h00000000005A, 6'h00,     48'h005A00AB0066, 48'h5A5A5A5A5A5A, 1'b0);
        vt[11] = mk(1'b0,1'b1,1'b1,4'd0, 4'd0, 4'd0, 48'h0,            6'h00,     48'h005A00AB0066, 48'h666666666666, 1'b0);
        vt[12] = mk(1'b0,1'b1,1'b1,4'd7, 4'd7, 4'd0, 48'h0,            6'h00,     48'h060004000200, 48'h0,            1'b0);

        // Reset state.
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_busy",   48'(busy),   48'h0);
        chk("rst_wr_err", 48'(wr_err), 48'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 16; a++) begin
            A1 = 4'(a); A2 = 4'(a);
            #1;
            chk("rst_rd1", RD1, 48'h0);
            chk("rst_rd2", RD2, 48'h0);
        end
        chk("rst_busy_after", 48'(busy), 48'h0);

        // Vector table: combinational reads with forwarding, then wr_err.
        for (int i = 0; i < 13; i++) begin
            WE3 = vt[i].we3; SFlag = vt[i].sflag; Bcast = vt[i].bcast;
            A1 = vt[i].a1; A2 = vt[i].a2; A3 = vt[i].a3;
            WD3 = vt[i].wd; WMask = vt[i].mask;
            #1;
            chk($sformatf("vec%0d_rd1", i), RD1, vt[i].e_rd1);
            chk($sformatf("vec%0d_rd2", i), RD2, vt[i].e_rd2);
            tick();
            chk($sformatf("vec%0d_wr_err", i), 48'(wr_err), 48'(vt[i].e_err));
        end
        idle_inputs();
        tick();
        chk("err_one_cycle", 48'(wr_err), 48'h0);

        // Load r3..r9, then run a clear with a write in its start cycle and a
        // write plus a repeated clr_req while it is running.
        for (int r = 3; r < 10; r++) begin
            WE3 = 1'b1; A3 = 4'(r); WMask = 6'h3F; WD3 = {6{8'(r * 17)}};
            tick();
        end
        idle_inputs();
        A1 = 4'd9;
        #1;
        chk("load_r9", RD1, {6{8'h99}});
        clr_req = 1'b1; WE3 = 1'b1; A3 = 4'd9; WMask = 6'h3F; WD3 = 48'h123456789ABC;
        tick();
        chk("clr_start_wr_err", 48'(wr_err), 48'h1);
        chk("clr_start_busy",   48'(busy),   48'h1);
        busy_cnt = 1;
        clr_req = 1'b0; WE3 = 1'b0;
        for (int c = 0; c < 15; c++) begin
            drove = (busy_cnt == 7);
            WE3 = drove; clr_req = drove; A3 = 4'd5; WD3 = 48'hDEADBEEFCAFE;
            tick();
            if (busy) busy_cnt++;
            chk("clr_wr_err", 48'(wr_err), 48'(drove));
        end
        idle_inputs();
        chk("clr_busy_cycles", 48'(busy_cnt), 48'd10);
        chk("clr_busy_end",    48'(busy),     48'h0);
        for (int r = 0; r < 10; r++) begin
            A1 = 4'(r);
            #1;
            chk($sformatf("clr_r%0d", r), RD1, 48'h0);
        end

        // Reset in the middle of a clear, then a fresh clear.
        for (int r = 7; r < 10; r++) begin
            WE3 = 1'b1; A3 = 4'(r); WMask = 6'h3F; WD3 = {6{8'(r * 17)}};
            tick();
        end
        idle_inputs();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        A1 = 4'd8; A2 = 4'd9;
        #1;
        chk("abort_rd1",    RD1,             48'h0);
        chk("abort_rd2",    RD2,             48'h0);
        chk("abort_busy",   48'(busy),       48'h0);
        chk("abort_wr_err", 48'(wr_err),     48'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = busy ? 1 : 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("fresh_clr_busy_cycles", 48'(busy_cnt), 48'd10);
        chk("fresh_clr_busy_end",    48'(busy),     48'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
